// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Purpose : Shared ALU-op, extension and width constants for the ID/EX slice.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int WIDTH      = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_operand_forward.sv
// ============================================================================
// Module  : operand_forward
// Purpose : Picks EX/MEM, then MEM/WB, then register-file data for one source.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module operand_forward #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic [WIDTH-1:0]      rf_data,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [WIDTH-1:0]      exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [WIDTH-1:0]      memwb_result,
  output logic [WIDTH-1:0]      fwd_data
);

  logic src_nonzero;
  logic exmem_hit;
  logic memwb_hit;

  // Register 0 is hard-wired, so it never takes a forwarded value.
  assign src_nonzero = (src_addr != '0);
  assign exmem_hit   = exmem_reg_write && (exmem_rd == src_addr) && src_nonzero;
  assign memwb_hit   = memwb_reg_write && (memwb_rd == src_addr) && src_nonzero;

  always_comb begin
    fwd_data = rf_data;
    if (exmem_hit) begin
      fwd_data = exmem_result;
    end else if (memwb_hit) begin
      fwd_data = memwb_result;
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module  : id_ex_stage
// Purpose : Decode-to-ALU pipeline register with forwarding and handshake.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
  parameter int WIDTH       = cpu_pkg::WIDTH,
  parameter int REG_ADDR_W  = cpu_pkg::REG_ADDR_W,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   InValid,
  output logic                   InReady,
  output logic                   OutValid,
  input  logic                   OutReady,
  input  logic                   Flush,
  input  logic [WIDTH-1:0]       RsData,
  input  logic [WIDTH-1:0]       RtData,
  input  logic [REG_ADDR_W-1:0]  RsAddr,
  input  logic [REG_ADDR_W-1:0]  RtAddr,
  input  logic [REG_ADDR_W-1:0]  RdAddr,
  input  logic [15:0]            Imm16,
  input  logic                   ExtSel,
  input  logic                   AluSrc,
  input  logic [1:0]             AluOpIn,
  input  logic                   RegWriteIn,
  input  logic                   ExMemRegWrite,
  input  logic [REG_ADDR_W-1:0]  ExMemRd,
  input  logic [WIDTH-1:0]       ExMemResult,
  input  logic                   MemWbRegWrite,
  input  logic [REG_ADDR_W-1:0]  MemWbRd,
  input  logic [WIDTH-1:0]       MemWbResult,
  output logic [WIDTH-1:0]       DataIn1,
  output logic [WIDTH-1:0]       DataIn2,
  output logic [1:0]             AluCtrl,
  output logic [REG_ADDR_W-1:0]  RdOut,
  output logic                   RegWriteOut,
  output logic                   IllegalOp,
  output logic [STALL_CNT_W-1:0] StallCount
);

  import cpu_pkg::*;

  logic [WIDTH-1:0] rs_fwd;
  logic [WIDTH-1:0] rt_fwd;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] op2_sel;
  logic [1:0]       alu_op_sel;
  logic             op_illegal;
  logic             capture;
  logic             stalled;

  operand_forward #(
    .WIDTH      (WIDTH),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_rs (
    .src_addr        (RsAddr),
    .rf_data         (RsData),
    .exmem_reg_write (ExMemRegWrite),
    .exmem_rd        (ExMemRd),
    .exmem_result    (ExMemResult),
    .memwb_reg_write (MemWbRegWrite),
    .memwb_rd        (MemWbRd),
    .memwb_result    (MemWbResult),
    .fwd_data        (rs_fwd)
  );

  operand_forward #(
    .WIDTH      (WIDTH),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_rt (
    .src_addr        (RtAddr),
    .rf_data         (RtData),
    .exmem_reg_write (ExMemRegWrite),
    .exmem_rd        (ExMemRd),
    .exmem_result    (ExMemResult),
    .memwb_reg_write (MemWbRegWrite),
    .memwb_rd        (MemWbRd),
    .memwb_result    (MemWbResult),
    .fwd_data        (rt_fwd)
  );

  assign InReady = !OutValid || OutReady;
  assign capture = InValid && InReady && !Flush;
  assign stalled = OutValid && !OutReady;

  assign imm_ext    = (ExtSel == EXT_SIGN) ? {{(WIDTH-16){Imm16[15]}}, Imm16}
                                           : {{(WIDTH-16){1'b0}}, Imm16};
  assign op2_sel    = AluSrc ? imm_ext : rt_fwd;
  // The undefined encoding 3 executes as an add and is flagged instead.
  assign op_illegal = (AluOpIn == 2'd3);
  assign alu_op_sel = op_illegal ? ALU_ADD : AluOpIn;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OutValid    <= 1'b0;
      DataIn1     <= '0;
      DataIn2     <= '0;
      AluCtrl     <= ALU_ADD;
      RdOut       <= '0;
      RegWriteOut <= 1'b0;
      IllegalOp   <= 1'b0;
    end else if (Flush) begin
      OutValid    <= 1'b0;
      RegWriteOut <= 1'b0;
    end else if (capture) begin
      OutValid    <= 1'b1;
      DataIn1     <= rs_fwd;
      DataIn2     <= op2_sel;
      AluCtrl     <= alu_op_sel;
      RdOut       <= RdAddr;
      RegWriteOut <= RegWriteIn;
      if (op_illegal) begin
        IllegalOp <= 1'b1;
      end
    end else if (OutReady) begin
      OutValid    <= 1'b0;
      RegWriteOut <= 1'b0;
    end
  end

  // Stall cycles count even when flushed in the same cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      StallCount <= '0;
    end else if (stalled && (StallCount != {STALL_CNT_W{1'b1}})) begin
      StallCount <= StallCount + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module  : tb_id_ex_stage
// Purpose : Directed self-checking bench for id_ex_stage.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

  logic        CLK;
  logic        RST;
  logic        InValid;
  logic        InReady;
  logic        OutValid;
  logic        OutReady;
  logic        Flush;
  logic [31:0] RsData;
  logic [31:0] RtData;
  logic [4:0]  RsAddr;
  logic [4:0]  RtAddr;
  logic [4:0]  RdAddr;
  logic [15:0] Imm16;
  logic        ExtSel;
  logic        AluSrc;
  logic [1:0]  AluOpIn;
  logic        RegWriteIn;
  logic        ExMemRegWrite;
  logic [4:0]  ExMemRd;
  logic [31:0] ExMemResult;
  logic        MemWbRegWrite;
  logic [4:0]  MemWbRd;
  logic [31:0] MemWbResult;
  logic [31:0] DataIn1;
  logic [31:0] DataIn2;
  logic [1:0]  AluCtrl;
  logic [4:0]  RdOut;
  logic        RegWriteOut;
  logic        IllegalOp;
  logic [15:0] StallCount;

  int checks;
  int errors;

  id_ex_stage #(
    .WIDTH       (32),
    .REG_ADDR_W  (5),
    .STALL_CNT_W (16)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .InValid       (InValid),
    .InReady       (InReady),
    .OutValid      (OutValid),
    .OutReady      (OutReady),
    .Flush         (Flush),
    .RsData        (RsData),
    .RtData        (RtData),
    .RsAddr        (RsAddr),
    .RtAddr        (RtAddr),
    .RdAddr        (RdAddr),
    .Imm16         (Imm16),
    .ExtSel        (ExtSel),
    .AluSrc        (AluSrc),
    .AluOpIn       (AluOpIn),
    .RegWriteIn    (RegWriteIn),
    .ExMemRegWrite (ExMemRegWrite),
    .ExMemRd       (ExMemRd),
    .ExMemResult   (ExMemResult),
    .MemWbRegWrite (MemWbRegWrite),
    .MemWbRd       (MemWbRd),
    .MemWbResult   (MemWbResult),
    .DataIn1       (DataIn1),
    .DataIn2       (DataIn2),
    .AluCtrl       (AluCtrl),
    .RdOut         (RdOut),
    .RegWriteOut   (RegWriteOut),
    .IllegalOp     (IllegalOp),
    .StallCount    (StallCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST = 1'b0;
    InValid = 0; OutReady = 1; Flush = 0;
    RsData = 0; RtData = 0; RsAddr = 0; RtAddr = 0; RdAddr = 0;
    Imm16 = 0; ExtSel = 0; AluSrc = 0; AluOpIn = 0; RegWriteIn = 0;
    ExMemRegWrite = 0; ExMemRd = 0; ExMemResult = 0;
    MemWbRegWrite = 0; MemWbRd = 0; MemWbResult = 0;
    #12;
    check("rst_outvalid", {31'd0, OutValid}, 32'd0);
    check("rst_inready", {31'd0, InReady}, 32'd1);
    check("rst_data1", DataIn1, 32'd0);
    check("rst_data2", DataIn2, 32'd0);
    check("rst_stall", {16'd0, StallCount}, 32'd0);
    check("rst_illegal", {31'd0, IllegalOp}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;

    // Single add
    RsData = 32'd5; RtData = 32'd7; RsAddr = 5'd1; RtAddr = 5'd2; RdAddr = 5'd4;
    RegWriteIn = 1; AluOpIn = 2'd0; InValid = 1;
    tick();
    check("add_valid", {31'd0, OutValid}, 32'd1);
    check("add_d1", DataIn1, 32'd5);
    check("add_d2", DataIn2, 32'd7);
    check("add_ctrl", {30'd0, AluCtrl}, 32'd0);
    check("add_rd", {27'd0, RdOut}, 32'd4);
    check("add_regwr", {31'd0, RegWriteOut}, 32'd1);
    InValid = 0;
    tick();
    check("add_drain_valid", {31'd0, OutValid}, 32'd0);
    check("add_drain_regwr", {31'd0, RegWriteOut}, 32'd0);

    // Immediate extension, back-to-back
    Imm16 = 16'hFFFC; ExtSel = 1; AluSrc = 1; AluOpIn = 2'd1; InValid = 1;
    tick();
    check("sext_d2", DataIn2, 32'hFFFF_FFFC);
    check("sext_ctrl", {30'd0, AluCtrl}, 32'd1);
    ExtSel = 0; AluOpIn = 2'd2;
    tick();
    check("zext_d2", DataIn2, 32'h0000_FFFC);
    check("zext_valid", {31'd0, OutValid}, 32'd1);
    check("zext_ctrl", {30'd0, AluCtrl}, 32'd2);

    // Forwarding priority
    AluSrc = 0; AluOpIn = 2'd0;
    RsAddr = 5'd3; RtAddr = 5'd3;
    ExMemRegWrite = 1; ExMemRd = 5'd3; ExMemResult = 32'h0000_AAAA;
    MemWbRegWrite = 1; MemWbRd = 5'd3; MemWbResult = 32'h0000_BBBB;
    tick();
    check("fwd_exmem_d1", DataIn1, 32'h0000_AAAA);
    check("fwd_exmem_d2", DataIn2, 32'h0000_AAAA);
    ExMemRegWrite = 0;
    tick();
    check("fwd_memwb_d2", DataIn2, 32'h0000_BBBB);
    ExMemRegWrite = 1; RsAddr = 5'd0; ExMemRd = 5'd0; MemWbRd = 5'd0;
    RtAddr = 5'd0;
    tick();
    check("fwd_r0_d1", DataIn1, 32'd5);
    check("fwd_r0_d2", DataIn2, 32'd7);
    ExMemRegWrite = 0; MemWbRegWrite = 0;
    InValid = 0;
    tick();
    check("pre_stall_cnt", {16'd0, StallCount}, 32'd0);

    // Stall
    RsData = 32'h11; OutReady = 0; InValid = 1;
    tick();
    check("stall_cap_valid", {31'd0, OutValid}, 32'd1);
    check("stall_inready", {31'd0, InReady}, 32'd0);
    RsData = 32'h22;
    tick();
    tick();
    tick();
    check("stall_cnt3", {16'd0, StallCount}, 32'd3);
    check("stall_frozen_d1", DataIn1, 32'h11);
    check("stall_hold_valid", {31'd0, OutValid}, 32'd1);
    OutReady = 1;
    #1;
    check("stall_release_inready", {31'd0, InReady}, 32'd1);
    tick();
    check("stall_newcap_d1", DataIn1, 32'h22);
    check("stall_newcap_valid", {31'd0, OutValid}, 32'd1);
    check("stall_cnt_hold", {16'd0, StallCount}, 32'd3);

    // Flush
    Flush = 1; RsData = 32'h33;
    tick();
    check("flush_valid", {31'd0, OutValid}, 32'd0);
    check("flush_regwr", {31'd0, RegWriteOut}, 32'd0);
    Flush = 0; InValid = 0;
    tick();
    check("flush_dropped", {31'd0, OutValid}, 32'd0);

    // Illegal op, sticky until reset
    AluOpIn = 2'd3; RsData = 32'h44; InValid = 1;
    tick();
    check("illegal_ctrl", {30'd0, AluCtrl}, 32'd0);
    check("illegal_flag", {31'd0, IllegalOp}, 32'd1);
    AluOpIn = 2'd2;
    tick();
    check("illegal_legal_ctrl", {30'd0, AluCtrl}, 32'd2);
    check("illegal_sticky", {31'd0, IllegalOp}, 32'd1);
    InValid = 0;
    RST = 1'b0;
    #1;
    check("rst2_illegal", {31'd0, IllegalOp}, 32'd0);
    check("rst2_valid", {31'd0, OutValid}, 32'd0);
    check("rst2_stall", {16'd0, StallCount}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
